cpu_clock_controller: RTL
=========================

# cpu_clock_controller

Run/halt/single-step clock-enable scheduler for the KGP miniRISC CPU on FPGA. Sequences a programmable divider: counts clk_in cycles, emits one-cycle `tick_en` pulses at period boundaries only when the FSM permits, and drives a ~50% `clk_out` square wave for LED observation. Sits between board switches/buttons, the CPU halt signal and the CPU datapath clock-enable inputs. Divisor changes are double-buffered and take effect only at a period boundary.

## Interface
- `CNT_W`, 32: divider counter and divisor width.
- `DEFAULT_DIV`, 32'd1000000: divisor loaded at reset.
- `MIN_DIV`, 32'd2: smallest legal divisor; smaller writes are clamped up to it.
- `clk_in` input 1: single clock, all logic on posedge.
- `rst_n` input 1: synchronous reset, active-low.
- `mode_run` input 1: asynchronous run switch; 1 = free-run, 0 = halt/step mode.
- `step_req` input 1: asynchronous step button, debounced externally.
- `halt_req` input 1: synchronous CPU halt indication, level.
- `div_wr` input 1: one-cycle divisor write strobe.
- `div_val` input CNT_W: new divisor, sampled when `div_wr`=1.
- `div_ack` output 1: one-cycle pulse when the pending divisor is applied.
- `tick_en` output 1: one-cycle CPU clock-enable pulse.
- `clk_out` output 1: divided square wave.
- `state` output 2: current FSM state.

## Operation
- Reset (`rst_n`=0 at a clk_in edge): counter=0, div_cur=DEFAULT_DIV, pend_valid=0, state=IDLE, tick_en=0, div_ack=0, clk_out=0, synchronizer flops=0.
- Counter free-runs in every state: counter <= (counter == div_cur-1) ? 0 : counter+1. Boundary = cycle with counter == div_cur-1.
- clk_out <= (counter < div_cur>>1); registered, floor division. Odd divisors give a high phase one cycle shorter than the low phase.
- States: IDLE=2'b00, RUN=2'b01, STEP=2'b10, HALTED=2'b11.
- IDLE: run_s=1 -> RUN; otherwise a step rising edge -> STEP.
- RUN: halt_req=1 -> HALTED, taking priority over any boundary in the same cycle (no tick). Otherwise run_s=0 -> IDLE. Otherwise tick_en=1 on each boundary.
- STEP: on boundary, tick_en=1 and -> IDLE. If halt_req=1 in the same cycle, -> HALTED instead, with no tick.
- HALTED: run_s=0 -> IDLE. Only reset or run_s=0 leaves HALTED.
- Step edges arriving in RUN, STEP or HALTED are discarded, not queued.
- Divisor write: div_pend <= max(div_val, MIN_DIV), pend_valid=1. A second write before application overwrites it; last write wins and produces one ack.
- At the next boundary with pend_valid=1: div_cur<=div_pend, counter<=0, pend_valid<=0, div_ack=1. A tick due on that boundary still fires.
- div_wr on a boundary cycle is applied at the following boundary, not the current one.
- Width rule: all compares are unsigned CNT_W; div_cur is never below MIN_DIV, so div_cur-1 never underflows.

## Timing
- `tick_en`, `div_ack`, `clk_out` and `state` are registered. Each pulse is asserted in the cycle after the boundary edge and lasts exactly 1 cycle.
- mode_run / step_req: 2-flop synchronizer plus 1 edge-detect flop. Step press to STEP state takes 3 cycles; STEP to tick takes at most div_cur cycles.
- RUN tick spacing is exactly div_cur cycles. A mid-RUN divisor change gives spacing of the old value up to the boundary, then the new value.
- Reset mid-period or mid-STEP discards the pending step and the pending divisor.

## Structure
- Package `clkctl_pkg`: state encoding constants, MIN_DIV default, CNT_W default.
- Sub-module `sync_edge`: 2-flop synchronizer + rising-edge detect with synchronous active-low reset. Instantiated twice: for step_req (edge output used) and mode_run (level output used).
- Top module contains the counter, divisor double-buffer and FSM.

## Test plan
- DEFAULT_DIV=4, mode_run=1 after reset -> tick_en pulses every 4 cycles; clk_out reads 1,1,0,0 repeating; state=01.
- mode_run=0, one step press -> exactly one tick_en within 3+4 cycles, state returns to 00; a second press during STEP -> no extra tick.
- RUN, halt_req=1 on a boundary cycle -> no tick, state=11; mode_run=0 -> state=00.
- div_wr with div_val=1 -> div_cur clamps to 2, div_ack once at the next boundary; ticks then every 2 cycles.
- Two div_wr (6 then 8) before a boundary -> single div_ack; tick spacing becomes 8.
- rst_n=0 mid-STEP with div write pending -> all outputs at reset values; div_cur=DEFAULT_DIV; no tick.

Source files
------------

// File: rtl/clkctl_pkg.sv
// clkctl_pkg: shared widths, divisor floor and FSM encoding for the CPU clock controller
// Contents: CNT_W_DEF (counter/divisor width), MIN_DIV_DEF (smallest legal divisor), state_t (FSM states)
package clkctl_pkg;
    localparam int CNT_W_DEF = 32;
    localparam logic [31:0] MIN_DIV_DEF = 32'd2;
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        STEP   = 2'b10,
        HALTED = 2'b11
    } state_t;
endpackage

// File: rtl/cpu_clock_controller_sync_edge.sv
// sync_edge: 2-flop synchronizer with optional rising-edge detect for asynchronous board inputs
// Ports: clk_in (clock), rst_n (sync active-low reset), d (async input),
//        q (synchronized level, or one-cycle rising-edge pulse when EDGE=1)
module sync_edge #(
    parameter bit EDGE = 1'b0
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [1:0] s;
    always_ff @(posedge clk_in) s <= !rst_n ? 2'b00 : {s[0], d};
    if (EDGE) begin : g_edge
        logic last;
        always_ff @(posedge clk_in) last <= !rst_n ? 1'b0 : s[1];
        assign q = s[1] & ~last;
    end else begin : g_level
        assign q = s[1];
    end
endmodule

// File: rtl/cpu_clock_controller.sv
// cpu_clock_controller: run/halt/single-step clock-enable scheduler with double-buffered programmable divider
// Ports: clk_in, rst_n (sync active-low); mode_run, step_req (async switch/button); halt_req (CPU halt level);
//        div_wr/div_val (divisor write); div_ack (divisor applied pulse); tick_en (CPU enable pulse);
//        clk_out (divided square wave); state (FSM state)
module cpu_clock_controller
    import clkctl_pkg::*;
#(
    parameter int               CNT_W       = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DEFAULT_DIV = 32'd1000000,
    parameter logic [CNT_W-1:0] MIN_DIV     = MIN_DIV_DEF
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             mode_run,
    input  logic             step_req,
    input  logic             halt_req,
    input  logic             div_wr,
    input  logic [CNT_W-1:0] div_val,
    output logic             div_ack,
    output logic             tick_en,
    output logic             clk_out,
    output logic [1:0]       state
);
    localparam logic [CNT_W-1:0] ONE = 1;
    state_t st;
    logic [CNT_W-1:0] counter, div_cur, div_pend;
    logic pend_valid, run_s, step_rise, boundary;
    sync_edge #(.EDGE(1'b0)) u_run  (.clk_in(clk_in), .rst_n(rst_n), .d(mode_run), .q(run_s));
    sync_edge #(.EDGE(1'b1)) u_step (.clk_in(clk_in), .rst_n(rst_n), .d(step_req), .q(step_rise));
    assign boundary = counter == div_cur - ONE;
    assign state = st;
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            counter    <= '0;
            div_cur    <= DEFAULT_DIV;
            div_pend   <= '0;
            pend_valid <= 1'b0;
            st         <= IDLE;
            tick_en    <= 1'b0;
            div_ack    <= 1'b0;
            clk_out    <= 1'b0;
        end else begin
            counter <= boundary ? '0 : counter + ONE;
            clk_out <= counter < (div_cur >> 1);
            tick_en <= 1'b0;
            div_ack <= 1'b0;
            if (boundary && pend_valid) begin
                div_cur    <= div_pend;
                pend_valid <= 1'b0;
                div_ack    <= 1'b1;
            end
            // a write on the applying boundary stays pending for the next one
            if (div_wr) begin
                div_pend   <= div_val < MIN_DIV ? MIN_DIV : div_val;
                pend_valid <= 1'b1;
            end
            case (st)
                IDLE:   st <= run_s ? RUN : step_rise ? STEP : IDLE;
                RUN:    if (halt_req) st <= HALTED;
                        else if (!run_s) st <= IDLE;
                        else tick_en <= boundary;
                STEP:   if (boundary) begin
                            st      <= halt_req ? HALTED : IDLE;
                            tick_en <= !halt_req;
                        end
                HALTED: if (!run_s) st <= IDLE;
            endcase
        end
    end
endmodule
